round_pack_float_param: RTL and testbench

ROUND_PACK_FLOAT_PARAM -- requirements
Module: round_pack_float_param

---
 rtl/round_pack_float_param.sv | 153 +++++++++++++++
 tb/tb_round_pack_float_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/round_pack_float_param.sv
// Rounds a wide significand to FRAC_W bits and packs sign/exponent/fraction into a float word,
// with a one-bit-per-cycle denormalising shifter behind an ap_start/ap_done handshake.
module round_pack_float_param #(
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 52,
  parameter int GRS_W  = 10,
  parameter int SIG_W  = FRAC_W + GRS_W + 2
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        ap_start,
  output logic                        ap_done,
  output logic                        ap_idle,
  output logic                        ap_ready,
  input  logic                        zSign,
  input  logic signed [EXP_W+1:0]     zExp,
  input  logic        [SIG_W-1:0]     zSig,
  input  logic        [1:0]           rmode,
  input  logic        [31:0]          flag_i,
  output logic        [31:0]          flag_o,
  output logic        [EXP_W+FRAC_W:0] ap_return
);
  localparam int RES_W = 1 + EXP_W + FRAC_W;
  localparam int CNT_W = $clog2(SIG_W + 1);
  localparam int MAXE  = (1 << EXP_W) - 3;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    CLASS  = 5'b00010,
    DENORM = 5'b00100,
    ROUND  = 5'b01000,
    DONE   = 5'b10000
  } state_t;

  state_t                   state_q;
  logic                     sign_q;
  logic signed [EXP_W+1:0]  exp_q;
  logic [SIG_W-1:0]         sig_q;
  logic [1:0]               rmode_q;
  logic [31:0]              flag_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     tiny_q;
  logic [RES_W-1:0]         ret_q;

  logic [SIG_W-1:0]         inc_d;
  logic [SIG_W-1:0]         sum_d;
  logic [SIG_W-1:0]         rnd_d;
  logic [SIG_W-1:0]         shift_d;
  logic [GRS_W-1:0]         rb_d;
  logic                     ovf_d;
  int                       neg_exp_d;
  logic [CNT_W-1:0]         cnt_init_d;
  logic [EXP_W-1:0]         pack_exp_d;
  logic [RES_W-1:0]         pack_d;
  logic [RES_W-1:0]         ovf_ret_d;
  logic [31:0]              rnd_flags_d;

  always_comb begin
    inc_d = '0;
    case (rmode_q)
      2'd0:    inc_d[GRS_W-1] = 1'b1;
      2'd2:    if (sign_q)  inc_d[GRS_W-1:0] = '1;
      2'd3:    if (!sign_q) inc_d[GRS_W-1:0] = '1;
      default: inc_d = '0;
    endcase
  end

  always_comb begin
    sum_d = sig_q + inc_d;
    rb_d  = sig_q[GRS_W-1:0];
    rnd_d = sum_d >> GRS_W;
    // Exact half under nearest-even: the increment already bumped us up, so drop back to even.
    if (rmode_q == 2'd0 && rb_d == {1'b1, {(GRS_W-1){1'b0}}}) rnd_d[0] = 1'b0;

    ovf_d      = (int'(exp_q) > MAXE) || (int'(exp_q) == MAXE && sum_d[SIG_W-1]);
    neg_exp_d  = -int'(exp_q);
    cnt_init_d = (neg_exp_d > SIG_W) ? CNT_W'(SIG_W) : CNT_W'(neg_exp_d);
    shift_d    = {1'b0, sig_q[SIG_W-1:2], sig_q[1] | sig_q[0]};

    // The hidden bit lands on the exponent LSB, so a rounding carry bumps the exponent for free.
    pack_exp_d = (rnd_d == '0) ? '0 : exp_q[EXP_W-1:0];
    pack_d     = {sign_q, pack_exp_d, {FRAC_W{1'b0}}} + RES_W'(rnd_d);
    ovf_ret_d  = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}} - RES_W'(inc_d == '0);

    rnd_flags_d    = '0;
    rnd_flags_d[0] = (rb_d != '0);
    rnd_flags_d[2] = tiny_q && (rb_d != '0);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      sig_q   <= '0;
      rmode_q <= '0;
      flag_q  <= '0;
      cnt_q   <= '0;
      tiny_q  <= 1'b0;
      ret_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ap_start) begin
            sign_q  <= zSign;
            exp_q   <= zExp;
            sig_q   <= zSig;
            rmode_q <= rmode;
            flag_q  <= flag_i;
            tiny_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= CLASS;
          end
        end
        CLASS: begin
          if (ovf_d) begin
            ret_q   <= ovf_ret_d;
            flag_q  <= flag_q | 32'h0000_0009;
            state_q <= DONE;
          end else if (exp_q < 0) begin
            exp_q   <= '0;
            tiny_q  <= 1'b1;
            cnt_q   <= cnt_init_d;
            state_q <= DENORM;
          end else begin
            state_q <= ROUND;
          end
        end
        DENORM: begin
          if (cnt_q != '0) begin
            sig_q <= shift_d;
            cnt_q <= cnt_q - CNT_W'(1);
          end
          if (cnt_q <= CNT_W'(1)) state_q <= ROUND;
        end
        ROUND: begin
          ret_q   <= pack_d;
          flag_q  <= flag_q | rnd_flags_d;
          state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ap_idle   = (state_q == IDLE);
  assign ap_done   = (state_q == DONE);
  assign ap_ready  = ap_done;
  assign flag_o    = ap_done ? flag_q : flag_i;
  assign ap_return = ret_q;

endmodule

// File: tb/tb_round_pack_float_param.sv
// Self-checking bench for round_pack_float_param: directed corner vectors, randomized operations
// against an arithmetic reference model, start-held-high sequencing and mid-operation reset.
module tb_round_pack_float_param;
  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic        zSign;
  logic [12:0] zExp;
  logic [63:0] zSig;
  logic [1:0]  rmode;
  logic [31:0] flag_i;
  logic [31:0] flag_o;
  logic [63:0] ap_return;

  int total = 0;
  int bad   = 0;

  round_pack_float_param dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .ap_start  (ap_start),
    .ap_done   (ap_done),
    .ap_idle   (ap_idle),
    .ap_ready  (ap_ready),
    .zSign     (zSign),
    .zExp      (zExp),
    .zSig      (zSig),
    .rmode     (rmode),
    .flag_i    (flag_i),
    .flag_o    (flag_o),
    .ap_return (ap_return)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: value-level rounding of the magnitude, sticky right shift, then float packing.
  function automatic void model(input logic s, input int e, input logic [63:0] sig_in,
                                input logic [1:0] rm, input logic [31:0] fin,
                                output logic [63:0] ret, output logic [31:0] fo, output int lat);
    logic [63:0]  sig, q, r;
    logic [127:0] wide, mask;
    int           n, ee;
    logic         tiny, inc_zero, ovf;
    inc_zero = (rm == 2'd1) || (rm == 2'd2 && !s) || (rm == 2'd3 && s);
    sig = sig_in; n = 0; ee = e; tiny = 1'b0;
    if (e < 0) begin
      n    = (-e > 64) ? 64 : -e;
      wide = {64'd0, sig_in};
      mask = (128'd1 << n) - 128'd1;
      sig  = 64'(wide >> n) | {63'd0, (wide & mask) != 128'd0};
      ee   = 0;
      tiny = 1'b1;
    end
    q = sig >> 10;
    r = sig & 64'h3FF;
    case (rm)
      2'd0:    if (r > 64'd512 || (r == 64'd512 && q[0])) q = q + 64'd1;
      2'd2:    if (s && r != 64'd0) q = q + 64'd1;
      2'd3:    if (!s && r != 64'd0) q = q + 64'd1;
      default: q = q;
    endcase
    ovf = (e > 2045) || (e == 2045 && q >= (64'd1 << 53));
    if (ovf) begin
      ret = inc_zero ? {s, 11'h7FE, 52'hF_FFFF_FFFF_FFFF} : {s, 11'h7FF, 52'd0};
      fo  = fin | 32'h9;
      lat = 2;
    end else begin
      if (q == 64'd0) ee = 0;
      ret = {s, 11'(ee), 52'd0} + q;
      fo  = fin | {29'd0, tiny && r != 64'd0, 1'b0, r != 64'd0};
      lat = 3 + n;
    end
  endfunction

  // Called #1 after an edge with the DUT idle; returns #1 after the edge that raised ap_done.
  task automatic do_op(input logic s, input int e, input logic [63:0] sig, input logic [1:0] rm,
                       input logic [31:0] fin, output logic [63:0] ret, output logic [31:0] fo,
                       output int lat);
    zSign = s; zExp = 13'(e); zSig = sig; rmode = rm; flag_i = fin; ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    zSign = ~s; zExp = 13'($urandom); zSig = {$urandom, $urandom};
    rmode = 2'($urandom); flag_i = $urandom;
    lat = 1;
    while (ap_done !== 1'b1 && lat < 100) begin
      @(posedge ap_clk); #1;
      lat++;
    end
    ret = ap_return;
    fo  = flag_o;
  endtask

  task automatic run_and_check(input string tag, input logic s, input int e, input logic [63:0] sig,
                               input logic [1:0] rm, input logic [31:0] fin,
                               input logic [63:0] er, input logic [31:0] ef, input int el);
    logic [63:0] ret;
    logic [31:0] fo;
    int          lat;
    do_op(s, e, sig, rm, fin, ret, fo, lat);
    $display("op %s s=%0d e=%0d sig=%h rm=%0d ret=%h flags=%h lat=%0d", tag, s, e, sig, rm, ret, fo, lat);
    check({tag, "_ret"}, ret, er);
    check({tag, "_flags"}, 64'(fo), 64'(ef));
    check({tag, "_lat"}, 64'(lat), 64'(el));
    check({tag, "_ready"}, 64'(ap_ready), 64'd1);
    @(posedge ap_clk); #1;
    check({tag, "_idle_after"}, 64'(ap_idle), 64'd1);
    check({tag, "_flag_pass"}, 64'(flag_o), 64'(flag_i));
  endtask

  initial begin
    logic [63:0] er, prev, exp_a;
    logic [31:0] ef;
    int          el, hl;
    logic        exp_done;

    ap_rst_n = 1'b0; ap_start = 1'b0; zSign = 1'b0; zExp = '0; zSig = '0; rmode = '0;
    flag_i = 32'h0000_1234;
    #12;
    check("rst_idle", 64'(ap_idle), 64'd1);
    check("rst_done", 64'(ap_done), 64'd0);
    check("rst_ready", 64'(ap_ready), 64'd0);
    check("rst_ret", ap_return, 64'd0);
    check("rst_flag_pass", 64'(flag_o), 64'h1234);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    flag_i = '0;

    run_and_check("exact",     1'b0, 'h3FE, 64'h4000_0000_0000_0000, 2'd0, 32'h0, 64'h3FF0_0000_0000_0000, 32'h0, 3);
    run_and_check("tie_rne",   1'b0, 'h3FE, 64'h4000_0000_0000_0200, 2'd0, 32'h0, 64'h3FF0_0000_0000_0000, 32'h1, 3);
    run_and_check("tie_rpi",   1'b0, 'h3FE, 64'h4000_0000_0000_0200, 2'd3, 32'h0, 64'h3FF0_0000_0000_0001, 32'h1, 3);
    run_and_check("ovf_rne",   1'b0, 'h7FE, 64'h4000_0000_0000_0000, 2'd0, 32'h0, 64'h7FF0_0000_0000_0000, 32'h9, 2);
    run_and_check("ovf_rz",    1'b0, 'h7FE, 64'h4000_0000_0000_0000, 2'd1, 32'h0, 64'h7FEF_FFFF_FFFF_FFFF, 32'h9, 2);
    run_and_check("ovf_flags", 1'b1, 'h7FE, 64'h4000_0000_0000_0000, 2'd1, 32'hF0, 64'hFFEF_FFFF_FFFF_FFFF, 32'hF9, 2);
    run_and_check("sub_exact", 1'b0, -1,    64'h4000_0000_0000_0000, 2'd0, 32'h0, 64'h0008_0000_0000_0000, 32'h0, 4);
    run_and_check("sub_inex",  1'b0, -1,    64'h4000_0000_0000_0001, 2'd0, 32'h0, 64'h0008_0000_0000_0000, 32'h5, 4);
    run_and_check("maxlat_up", 1'b0, -100,  64'h4000_0000_0000_0000, 2'd3, 32'h0, 64'h0000_0000_0000_0001, 32'h5, 67);
    run_and_check("maxlat_ng", 1'b1, -100,  64'h4000_0000_0000_0000, 2'd3, 32'h0, 64'h8000_0000_0000_0000, 32'h5, 67);
    run_and_check("maxe_cry",  1'b0, 2045,  64'h7FFF_FFFF_FFFF_FFFF, 2'd0, 32'h0, 64'h7FF0_0000_0000_0000, 32'h9, 2);
    run_and_check("maxe_norm", 1'b0, 2045,  64'h4000_0000_0000_0000, 2'd0, 32'h0, 64'h7FE0_0000_0000_0000, 32'h0, 3);

    for (int i = 0; i < 150; i++) begin
      logic        s;
      int          e;
      logic [63:0] sig;
      logic [1:0]  rm;
      logic [31:0] fin;
      s = 1'($urandom); rm = 2'($urandom); fin = $urandom;
      case ($urandom_range(0, 4))
        0:       e = -int'($urandom_range(1, 80));
        1:       e = int'($urandom_range(0, 2047));
        2:       e = 2045;
        3:       e = int'($urandom_range(2046, 4095));
        default: e = int'($urandom_range(1, 2044));
      endcase
      sig = {2'b01, 30'($urandom), $urandom};
      case ($urandom_range(0, 5))
        0:       sig[9:0] = 10'h200;
        1:       sig[9:0] = 10'h000;
        2:       sig[61:0] = '1;
        default: sig = sig;
      endcase
      model(s, e, sig, rm, fin, er, ef, el);
      run_and_check("rand", s, e, sig, rm, fin, er, ef, el);
    end

    // ap_start held high: one pulse per accepted start, result stable between pulses.
    prev = ap_return;
    model(1'b0, -5, 64'h4000_0000_0000_0000, 2'd0, 32'h0, exp_a, ef, hl);
    zSign = 1'b0; zExp = 13'(-5); zSig = 64'h4000_0000_0000_0000; rmode = 2'd0; flag_i = 32'h0;
    ap_start = 1'b1;
    for (int k = 0; k < 3 * (hl + 1); k++) begin
      @(posedge ap_clk); #1;
      exp_done = (k >= hl - 1) && (((k - (hl - 1)) % (hl + 1)) == 0);
      check("hold_done", 64'(ap_done), 64'(exp_done));
      check("hold_ret", ap_return, (k >= hl - 1) ? exp_a : prev);
      $display("op hold cycle=%0d done=%0d ret=%h", k, ap_done, ap_return);
    end
    ap_start = 1'b0;

    // Asynchronous reset in the middle of a long denormalisation.
    zSign = 1'b0; zExp = 13'(-40); zSig = 64'h4000_0000_0000_0000; rmode = 2'd0; flag_i = 32'h0;
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    repeat (5) begin
      @(posedge ap_clk); #1;
    end
    check("midrst_busy", 64'(ap_idle), 64'd0);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("midrst_idle", 64'(ap_idle), 64'd1);
    check("midrst_ret", ap_return, 64'd0);
    check("midrst_done", 64'(ap_done), 64'd0);
    check("midrst_ready", 64'(ap_ready), 64'd0);
    $display("op midrst idle=%0d ret=%h", ap_idle, ap_return);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;

    run_and_check("post_rst", 1'b0, 'h3FE, 64'h4000_0000_0000_0200, 2'd3, 32'h0, 64'h3FF0_0000_0000_0001, 32'h1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
